pipelined_prefix_addsub: RTL

- Parametrised, fully pipelined Kogge-Stone parallel-prefix adder/subtractor.
- Generalises the team's fixed 16-bit pipelined CLA to any power-of-two WIDTH.
- Adds a subtract mode, a correct carry-out, signed overflow, synchronous reset, and a valid/ready handshake with backpressure.
- Sits in the datapath as a streaming arithmetic unit with one operation accepted per cycle.

---
 rtl/pipelined_prefix_addsub_if.sv | 27 ++
 rtl/pipelined_prefix_addsub.sv | 86 ++++++++
 2 files changed

// File: rtl/pipelined_prefix_addsub_if.sv
// Streaming handshake bundle for pipelined_prefix_addsub: operand beat in,
// result beat out, valid/ready on each side.
interface pipelined_prefix_addsub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_prefix_addsub.sv
// Fully pipelined Kogge-Stone adder/subtractor: one prefix level per register
// stage, global stall on backpressure, carry-in folded in as position -1.
module pipelined_prefix_addsub #(
   parameter int WIDTH = 32
) (
   input logic                clk,
   input logic                rst,
   pipelined_prefix_addsub_if.slave bus
);
   localparam int LOG2W = $clog2(WIDTH);

   if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("pipelined_prefix_addsub: WIDTH must be a power of two in 4..64");
   end

   // Vector index e holds prefix position e-1, so bit 0 is the carry-in slot
   // and the final g[i] is exactly the carry into sum bit i.
   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] h;
      logic             am;
      logic             bm;
   } stage_t;

   function automatic stage_t combine(input stage_t s, input int span);
      stage_t r;
      r = s;
      for (int i = span; i < WIDTH; i++) begin
         r.g[i] = s.g[i] | (s.p[i] & s.g[i-span]);
         r.p[i] = s.p[i] & s.p[i-span];
      end
      return r;
   endfunction

   logic [WIDTH-1:0] bb;
   logic [WIDTH-1:0] h0;
   logic             c0;
   logic             adv;
   stage_t           pre;
   stage_t           last;
   logic [WIDTH-1:0] sum_w;
   stage_t           lvl_in [LOG2W];
   stage_t           lvl_q  [LOG2W];

   assign bb  = bus.sub ? ~bus.b : bus.b;
   assign c0  = bus.sub | bus.cin;
   assign h0  = bus.a ^ bb;
   assign pre = '{v:  bus.in_valid,
                  g:  {bus.a[WIDTH-2:0] & bb[WIDTH-2:0], c0},
                  p:  {h0[WIDTH-2:0], 1'b0},
                  h:  h0,
                  am: bus.a[WIDTH-1],
                  bm: bb[WIDTH-1]};

   for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
      if (k == 0) begin : g_first
         assign lvl_in[k] = pre;
      end else begin : g_next
         assign lvl_in[k] = lvl_q[k-1];
      end
   end

   // Every stage shifts together, bubbles included, so a stalled pipe is frozen.
   assign adv          = !last.v || bus.out_ready;
   assign bus.in_ready = adv;

   // NOTE: data registers are cleared along with the valid bits so an empty
   // pipe presents all-zero results rather than stale operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LOG2W; k++) lvl_q[k] <= '0;
      end else if (adv) begin
         for (int k = 0; k < LOG2W; k++) lvl_q[k] <= combine(lvl_in[k], 1 << k);
      end
   end

   // The prefix tree covers positions -1..W-2; the MSB carry is finished here.
   assign last          = lvl_q[LOG2W-1];
   assign sum_w         = last.h ^ last.g;
   assign bus.out_valid = last.v;
   assign bus.sum       = sum_w;
   assign bus.cout      = (last.am & last.bm) | (last.h[WIDTH-1] & last.g[WIDTH-1]);
   assign bus.ovf       = (last.am == last.bm) && (sum_w[WIDTH-1] != last.am);
endmodule
